// File: rtl/clock_rate_controller.sv
// Programmable clock divider with burst length, queued rate change and graceful stop.
// Rate changes and stops take effect only at a period wrap.
module clock_rate_controller #(
  parameter logic [28:0] DEFAULT_DIVISOR = 29'd2
) (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [28:0] req_divisor,
  input  logic [7:0]  req_burst,
  output logic        req_ready,
  input  logic        stop,
  output logic        clock_out,
  output logic        tick,
  output logic        burst_done,
  output logic        err,
  output logic        busy,
  output logic [28:0] active_divisor
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [28:0] r_cnt;
  logic [28:0] r_active;
  logic [7:0]  r_burst;
  logic [7:0]  r_period;
  logic        r_pend_v;
  logic [28:0] r_pend_div;
  logic [7:0]  r_pend_burst;
  logic        r_stop;
  logic        r_done;
  logic        r_err;

  logic        w_run;
  logic        w_hs;
  logic        w_bad;
  logic        w_acc;
  logic        w_wrap;
  logic        w_stop;
  logic        w_pv;
  logic [28:0] w_pdiv;
  logic [7:0]  w_pburst;
  logic [7:0]  w_pnext;
  logic        w_fin;

  assign w_run    = (r_state == S_RUN);
  assign w_hs     = req_valid && req_ready;
  assign w_bad    = (req_divisor < 29'd2);
  assign w_acc    = w_hs && !w_bad;
  assign w_wrap   = w_run && (r_cnt == r_active - 29'd1);
  assign w_stop   = r_stop || stop;
  // A request accepted on the wrap edge itself counts as pending for that wrap
  assign w_pv     = r_pend_v || (w_acc && w_run);
  assign w_pdiv   = r_pend_v ? r_pend_div : req_divisor;
  assign w_pburst = r_pend_v ? r_pend_burst : req_burst;
  assign w_pnext  = r_period + 8'd1;
  assign w_fin    = (r_burst != 8'd0) && (w_pnext == r_burst);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_active     <= DEFAULT_DIVISOR;
      r_burst      <= '0;
      r_period     <= '0;
      r_pend_v     <= 1'b0;
      r_pend_div   <= '0;
      r_pend_burst <= '0;
      r_stop       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err  <= w_hs && w_bad;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state  <= S_RUN;
            r_active <= req_divisor;
            r_burst  <= req_burst;
            r_cnt    <= '0;
            r_period <= '0;
          end
        end
        S_RUN: begin
          if (stop) r_stop <= 1'b1;
          if (w_acc) begin
            r_pend_v     <= 1'b1;
            r_pend_div   <= req_divisor;
            r_pend_burst <= req_burst;
          end
          if (!w_wrap) begin
            r_cnt <= r_cnt + 29'd1;
          end else begin
            r_cnt    <= '0;
            r_period <= w_pnext;
            // Stop wins over a pending request, which wins over burst end
            if (w_stop) begin
              r_state  <= S_IDLE;
              r_stop   <= 1'b0;
              r_pend_v <= 1'b0;
            end else if (w_pv) begin
              r_active <= w_pdiv;
              r_burst  <= w_pburst;
              r_period <= '0;
              r_pend_v <= 1'b0;
            end else if (w_fin) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready      = !w_run || !r_pend_v;
  assign clock_out      = w_run && (r_cnt < (r_active >> 1));
  assign tick           = w_run && (r_cnt == 29'd0);
  assign busy           = w_run;
  assign burst_done     = r_done;
  assign err            = r_err;
  assign active_divisor = r_active;

endmodule
